// File: rtl/bus_target_unit_v35.sv
// V35 external-bus target: decodes CPU memory/IO cycles, holds ready low while each one is
// forwarded as a single word-wide req/ack transaction. Optional macro: BUS_TIMEOUT_EN.
module bus_target_unit_v35 #(
   parameter int unsigned MEM_WAIT = 0,
   parameter int unsigned IO_WAIT  = 1,
   parameter int unsigned TIMEOUT  = 64
) (
   input  logic        i_clk,
   input  logic        i_n_reset,
   input  logic        i_ce_1,
   input  logic        i_ce_2,
   input  logic        i_n_mreq,
   input  logic        i_n_mstb,
   input  logic        i_n_iostb,
   input  logic        i_r_w,
   input  logic        i_n_ube,
   input  logic [19:0] i_addr,
   input  logic [15:0] i_bus_wdata,
   input  logic        i_intack_cycle,
   output logic        o_ready,
   output logic [15:0] o_bus_rdata,
   output logic        o_mem_req,
   input  logic        i_mem_ack,
   output logic        o_mem_we,
   output logic        o_mem_io,
   output logic [18:0] o_mem_addr,
   output logic [1:0]  o_mem_be,
   output logic [15:0] o_mem_wdata,
   input  logic [15:0] i_mem_rdata,
   output logic        o_bus_error
);

   localparam int unsigned MAXW = (MEM_WAIT > IO_WAIT) ? MEM_WAIT : IO_WAIT;
   localparam int WCW = (MAXW > 0) ? $clog2(MAXW + 1) : 1;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WAIT   = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]     r_state;
   logic [WCW-1:0] r_wcnt;
   logic           r_ack;
   logic           r_ready;
   logic [15:0]    r_bus_rdata;
   logic           r_mem_req;
   logic           r_mem_we;
   logic           r_mem_io;
   logic [18:0]    r_mem_addr;
   logic [1:0]     r_mem_be;
   logic [15:0]    r_mem_wdata;

   logic           w_ce;
   logic           w_strobe;
   logic           w_start;
   logic [1:0]     w_be;
   logic [WCW-1:0] w_wait_ld;
   logic [15:0]    w_rdata_lanes;

   assign w_ce      = i_ce_1 | i_ce_2;
   assign w_strobe  = ~i_n_mstb | ~i_n_iostb;
   assign w_start   = i_ce_2 & ~i_n_mreq & w_strobe;
   assign w_be      = {~i_n_ube, ~i_addr[0]};
   assign w_wait_ld = i_n_iostb ? WCW'(MEM_WAIT) : WCW'(IO_WAIT);

   // Unselected lanes read back as floating-bus ones.
   assign w_rdata_lanes = {r_mem_be[1] ? i_mem_rdata[15:8] : 8'hff,
                           r_mem_be[0] ? i_mem_rdata[7:0]  : 8'hff};

`ifdef BUS_TIMEOUT_EN
   localparam int TOW = $clog2(TIMEOUT + 1);
   logic [TOW-1:0] r_to_cnt;
   logic           r_bus_error;
   assign o_bus_error = r_bus_error;
`else
   logic w_unused_to;
   assign w_unused_to = (TIMEOUT == 0);
   assign o_bus_error = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_n_reset) begin
      if (!i_n_reset) begin
         r_state     <= S_IDLE;
         r_wcnt      <= '0;
         r_ack       <= 1'b0;
         r_ready     <= 1'b1;
         r_bus_rdata <= 16'hffff;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_io    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_be    <= '0;
         r_mem_wdata <= '0;
`ifdef BUS_TIMEOUT_EN
         r_to_cnt    <= '0;
         r_bus_error <= 1'b0;
`endif
      end else begin
`ifdef BUS_TIMEOUT_EN
         r_bus_error <= 1'b0;
`endif
         // Ack is taken on any clk; completion toward the CPU waits for a phase edge.
         if (r_mem_req && i_mem_ack) begin
            r_mem_req <= 1'b0;
            r_ack     <= 1'b1;
            if (!r_mem_we) r_bus_rdata <= w_rdata_lanes;
         end

         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_mem_addr  <= i_addr[19:1];
                  r_mem_be    <= w_be;
                  r_mem_we    <= ~i_r_w;
                  r_mem_io    <= ~i_n_iostb;
                  r_mem_wdata <= i_bus_wdata;
                  r_ack       <= 1'b0;
                  r_ready     <= 1'b0;
                  if (i_intack_cycle || (w_be == 2'b00)) begin
                     r_bus_rdata <= 16'hffff;
                     r_state     <= S_DONE;
                  end else if (w_wait_ld != '0) begin
                     r_wcnt  <= w_wait_ld;
                     r_state <= S_WAIT;
                  end else begin
                     r_mem_req <= 1'b1;
`ifdef BUS_TIMEOUT_EN
                     r_to_cnt  <= '0;
`endif
                     r_state   <= S_ACCESS;
                  end
               end
            end

            S_WAIT: begin
               // CPU dropped its strobes before the access was issued: nothing to finish.
               if (w_ce && !w_strobe) begin
                  r_ready <= 1'b1;
                  r_state <= S_IDLE;
               end else if (i_ce_1) begin
                  r_wcnt <= r_wcnt - WCW'(1);
                  if (r_wcnt == WCW'(1)) begin
                     r_mem_req <= 1'b1;
`ifdef BUS_TIMEOUT_EN
                     r_to_cnt  <= '0;
`endif
                     r_state   <= S_ACCESS;
                  end
               end
            end

            S_ACCESS: begin
               if (w_ce && r_ack) begin
                  r_ready <= 1'b1;
                  r_state <= S_DONE;
               end
`ifdef BUS_TIMEOUT_EN
               else if (i_ce_1) begin
                  if (r_to_cnt == TOW'(TIMEOUT - 1)) begin
                     r_mem_req   <= 1'b0;
                     r_bus_rdata <= 16'hffff;
                     r_bus_error <= 1'b1;
                     r_ready     <= 1'b1;
                     r_state     <= S_DONE;
                  end else begin
                     r_to_cnt <= r_to_cnt + TOW'(1);
                  end
               end
`endif
            end

            S_DONE: begin
               // Strobes must go high before another cycle can be decoded.
               if (w_ce) begin
                  r_ready <= 1'b1;
                  if (i_n_mstb && i_n_iostb) r_state <= S_IDLE;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_ready     = r_ready;
   assign o_bus_rdata = r_bus_rdata;
   assign o_mem_req   = r_mem_req;
   assign o_mem_we    = r_mem_we;
   assign o_mem_io    = r_mem_io;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_be    = r_mem_be;
   assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_bus_target_unit_v35.sv
// Bench for bus_target_unit_v35: directed and randomized CPU cycles against a transaction-level model.
module tb_bus_target_unit_v35;

   localparam int MEM_WAIT = 0;
   localparam int IO_WAIT  = 3;
   localparam int TIMEOUT  = 64;

   logic        clk = 1'b0;
   logic        n_reset;
   logic        ce_1, ce_2;
   logic        n_mreq, n_mstb, n_iostb, r_w, n_ube, intack_cycle;
   logic [19:0] addr;
   logic [15:0] bus_wdata;
   logic        ready;
   logic [15:0] bus_rdata;
   logic        mem_req, mem_ack, mem_we, mem_io;
   logic [18:0] mem_addr;
   logic [1:0]  mem_be;
   logic [15:0] mem_wdata, mem_rdata;
   logic        bus_error;

   int checks = 0;
   int errors = 0;

   // backing-side model state
   int          ack_dly = 1;
   logic [15:0] next_rdata = 16'h0;
   int          txn_cnt = 0;
   logic [18:0] rec_addr;
   logic [1:0]  rec_be;
   logic        rec_we, rec_io;
   logic [15:0] rec_wdata, rec_rdata;
   int          err_pulses = 0;

   bus_target_unit_v35 #(.MEM_WAIT(MEM_WAIT), .IO_WAIT(IO_WAIT), .TIMEOUT(TIMEOUT)) dut (
      .i_clk(clk), .i_n_reset(n_reset), .i_ce_1(ce_1), .i_ce_2(ce_2),
      .i_n_mreq(n_mreq), .i_n_mstb(n_mstb), .i_n_iostb(n_iostb), .i_r_w(r_w),
      .i_n_ube(n_ube), .i_addr(addr), .i_bus_wdata(bus_wdata),
      .i_intack_cycle(intack_cycle), .o_ready(ready), .o_bus_rdata(bus_rdata),
      .o_mem_req(mem_req), .i_mem_ack(mem_ack), .o_mem_we(mem_we), .o_mem_io(mem_io),
      .o_mem_addr(mem_addr), .o_mem_be(mem_be), .o_mem_wdata(mem_wdata),
      .i_mem_rdata(mem_rdata), .o_bus_error(bus_error)
   );

   always #5 clk = ~clk;

   // CPU phase enables: ce_1 then ce_2, two clocks apart
   initial begin
      int phase;
      phase = 3;
      ce_1 = 1'b0;
      ce_2 = 1'b0;
      forever begin
         @(negedge clk);
         phase = (phase + 1) % 4;
         ce_1 = (phase == 0);
         ce_2 = (phase == 2);
      end
   end

   // Backing memory: records each request, acks ack_dly clocks later (0 = never)
   initial begin
      mem_ack = 1'b0;
      mem_rdata = 16'h0;
      forever begin
         @(posedge clk); #1;
         if (mem_req === 1'b1) begin
            txn_cnt++;
            rec_addr = mem_addr; rec_be = mem_be; rec_we = mem_we;
            rec_io = mem_io; rec_wdata = mem_wdata;
            if (ack_dly == 0) begin
               while (mem_req === 1'b1) begin @(posedge clk); #1; end
            end else begin
               repeat (ack_dly - 1) begin @(posedge clk); #1; end
               mem_rdata = next_rdata;
               rec_rdata = next_rdata;
               mem_ack = 1'b1;
               @(posedge clk); #1;
               mem_ack = 1'b0;
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         if (bus_error === 1'b1) err_pulses++;
      end
   end

   // Drives one CPU cycle and reports what was seen; comparisons are done by the callers.
   task automatic run_cycle(input logic [19:0] a, input logic ube_n, input logic rd,
                            input logic io, input logic ia, input logic [15:0] wd,
                            input int bound, input bit keep,
                            output bit done, output int edges, output int ce1n,
                            output int pulses, output logic [15:0] rdo);
      bit   det;
      logic c1, c2, prev;
      int   cnt;
      @(negedge clk);
      addr = a; n_ube = ube_n; r_w = rd; intack_cycle = ia; bus_wdata = wd;
      n_mreq = 1'b0;
      if (io) n_iostb = 1'b0; else n_mstb = 1'b0;
      det = 0; done = 0; edges = 0; ce1n = -1; pulses = 0; cnt = 0; prev = mem_req;
      for (int k = 0; k < bound && !done; k++) begin
         @(posedge clk);
         c1 = ce_1; c2 = ce_2;
         if (det) begin
            edges++;
            if (c1) cnt++;
         end else if (c2) det = 1;
         #1;
         if (mem_req === 1'b1 && prev !== 1'b1) begin
            pulses++;
            if (ce1n < 0) ce1n = cnt;
         end
         prev = mem_req;
         if (det && ready === 1'b1) done = 1;
      end
      rdo = bus_rdata;
      if (!keep) begin
         @(negedge clk);
         n_mstb = 1'b1; n_iostb = 1'b1; n_mreq = 1'b1;
         repeat (4) @(posedge clk);
      end
   endtask

   function automatic logic [15:0] lanes(input logic [1:0] be, input logic [15:0] d);
      return {be[1] ? d[15:8] : 8'hff, be[0] ? d[7:0] : 8'hff};
   endfunction

   task automatic test_reset;
      n_reset = 1'b0;
      n_mreq = 1'b1; n_mstb = 1'b1; n_iostb = 1'b1; r_w = 1'b1; n_ube = 1'b1;
      intack_cycle = 1'b0; addr = '0; bus_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (ready !== 1'b1 || bus_rdata !== 16'hffff) begin
         errors++; $display("FAIL reset_bus: ready=%b rdata=%h, want 1 ffff", ready, bus_rdata);
      end
      checks++;
      if ({mem_req, mem_we, mem_io, mem_be} !== 5'b0 || mem_addr !== 19'h0 || mem_wdata !== 16'h0) begin
         errors++;
         $display("FAIL reset_mem: req=%b we=%b io=%b be=%b addr=%h wd=%h, want all 0",
                  mem_req, mem_we, mem_io, mem_be, mem_addr, mem_wdata);
      end
      checks++;
      if (bus_error !== 1'b0) begin
         errors++; $display("FAIL reset_err: bus_error=%b want 0", bus_error);
      end
      @(negedge clk);
      n_reset = 1'b1;
      repeat (4) @(posedge clk);
   endtask

   task automatic test_word_read;
      bit done; int edges, ce1n, pulses, t0; logic [15:0] rd;
      t0 = txn_cnt; ack_dly = 2; next_rdata = 16'hBEEF;
      run_cycle(20'h12340, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 200, 0, done, edges, ce1n, pulses, rd);
      checks++;
      if (!done || edges < 1) begin
         errors++; $display("FAIL word_read_ready: done=%0d edges=%0d, want done with >=1 wait", done, edges);
      end
      checks++;
      if (rec_addr !== 19'h091A0 || rec_be !== 2'b11 || rec_we !== 1'b0) begin
         errors++; $display("FAIL word_read_req: addr=%h be=%b we=%b, want 091a0 11 0", rec_addr, rec_be, rec_we);
      end
      checks++;
      if (rd !== 16'hBEEF) begin
         errors++; $display("FAIL word_read_data: rdata=%h want beef", rd);
      end
      checks++;
      if (pulses != 1 || txn_cnt - t0 != 1) begin
         errors++; $display("FAIL word_read_pulses: pulses=%0d txns=%0d want 1 1", pulses, txn_cnt - t0);
      end
   endtask

   task automatic test_byte_write;
      bit done; int edges, ce1n, pulses; logic [15:0] rd;
      ack_dly = 1;
      run_cycle(20'h00101, 1'b0, 1'b0, 1'b0, 1'b0, 16'h5A00, 200, 0, done, edges, ce1n, pulses, rd);
      checks++;
      if (!done || rec_addr !== 19'h00080 || rec_be !== 2'b10 || rec_we !== 1'b1 || rec_wdata !== 16'h5A00) begin
         errors++;
         $display("FAIL byte_write: done=%0d addr=%h be=%b we=%b wd=%h, want 1 00080 10 1 5a00",
                  done, rec_addr, rec_be, rec_we, rec_wdata);
      end
      checks++;
      if (mem_req !== 1'b0) begin
         errors++; $display("FAIL byte_write_req_drop: mem_req=%b want 0", mem_req);
      end
   endtask

   task automatic test_io_wait;
      bit done; int edges, ce1n, pulses; logic [15:0] rd;
      ack_dly = 1; next_rdata = 16'h1234;
      run_cycle(20'h00040, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 200, 0, done, edges, ce1n, pulses, rd);
      checks++;
      if (ce1n != IO_WAIT) begin
         errors++; $display("FAIL io_wait_ticks: ce_1 ticks before req=%0d want %0d", ce1n, IO_WAIT);
      end
      checks++;
      if (!done || rec_io !== 1'b1 || rd !== 16'h1234) begin
         errors++; $display("FAIL io_read: done=%0d io=%b rdata=%h want 1 1 1234", done, rec_io, rd);
      end
   endtask

   task automatic test_no_access;
      bit done; int edges, ce1n, pulses, t0; logic [15:0] rd;
      ack_dly = 1;
      for (int m = 0; m < 2; m++) begin
         t0 = txn_cnt;
         if (m == 0)
            run_cycle(20'h00101, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 200, 0, done, edges, ce1n, pulses, rd);
         else
            run_cycle(20'h00200, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0, 200, 0, done, edges, ce1n, pulses, rd);
         checks++;
         if (!done || edges < 1 || pulses != 0 || txn_cnt != t0 || rd !== 16'hffff) begin
            errors++;
            $display("FAIL no_access_%0d: done=%0d edges=%0d pulses=%0d rdata=%h, want 1 >=1 0 ffff",
                     m, done, edges, pulses, rd);
         end
      end
   endtask

   task automatic test_back_to_back;
      bit done; int edges, ce1n, pulses, t0; logic [15:0] rd; bit bad;
      ack_dly = 1; next_rdata = 16'hA55A;
      t0 = txn_cnt;
      run_cycle(20'h00010, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 200, 1, done, edges, ce1n, pulses, rd);
      bad = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (ready !== 1'b1 || mem_req !== 1'b0) bad = 1;
      end
      checks++;
      if (!done || bad || txn_cnt - t0 != 1) begin
         errors++; $display("FAIL back_to_back_hold: done=%0d bad=%0d txns=%0d want 1 0 1", done, bad, txn_cnt - t0);
      end
      @(negedge clk);
      n_mstb = 1'b1; n_iostb = 1'b1; n_mreq = 1'b1;
      repeat (4) @(posedge clk);
      next_rdata = 16'h0F0F;
      run_cycle(20'h00020, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 200, 0, done, edges, ce1n, pulses, rd);
      checks++;
      if (!done || txn_cnt - t0 != 2 || rd !== 16'h0F0F) begin
         errors++; $display("FAIL back_to_back_next: done=%0d txns=%0d rdata=%h want 1 2 0f0f", done, txn_cnt - t0, rd);
      end
   endtask

   task automatic test_reset_access;
      bit done, seen; int edges, ce1n, pulses; logic [15:0] rd;
      ack_dly = 0;
      @(negedge clk);
      addr = 20'h0ABC0; n_ube = 1'b0; r_w = 1'b1; intack_cycle = 1'b0;
      n_mreq = 1'b0; n_mstb = 1'b0;
      seen = 0;
      for (int k = 0; k < 50 && !seen; k++) begin
         @(posedge clk); #1;
         if (mem_req === 1'b1) seen = 1;
      end
      @(negedge clk);
      n_reset = 1'b0;
      #1;
      checks++;
      if (!seen || mem_req !== 1'b0 || ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_access: seen=%0d req=%b ready=%b want 1 0 1", seen, mem_req, ready);
      end
      n_mstb = 1'b1; n_mreq = 1'b1;
      @(negedge clk);
      n_reset = 1'b1;
      repeat (4) @(posedge clk);
      ack_dly = 3; next_rdata = 16'hC3C3;
      run_cycle(20'h00402, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 200, 0, done, edges, ce1n, pulses, rd);
      checks++;
      if (!done || rec_addr !== 19'h00201 || rec_be !== 2'b01 || rd !== 16'hFFC3) begin
         errors++;
         $display("FAIL after_reset_cycle: done=%0d addr=%h be=%b rdata=%h want 1 00201 01 ffc3",
                  done, rec_addr, rec_be, rd);
      end
   endtask

   task automatic test_random;
      bit done; int edges, ce1n, pulses, t0, exp_w; logic [15:0] rd, wd, exp_rd;
      logic [19:0] a; logic ube_n, rd_n, io, ia; logic [1:0] be; bit access;
      for (int n = 0; n < 24; n++) begin
         a = 20'($urandom); ube_n = 1'($urandom); rd_n = 1'($urandom); io = 1'($urandom);
         ia = ($urandom_range(7, 0) == 0); wd = 16'($urandom);
         ack_dly = $urandom_range(4, 1); next_rdata = 16'($urandom);
         be = {~ube_n, ~a[0]};
         access = !ia && (be != 2'b00);
         exp_w = io ? IO_WAIT : MEM_WAIT;
         t0 = txn_cnt;
         run_cycle(a, ube_n, rd_n, io, ia, wd, 300, 0, done, edges, ce1n, pulses, rd);
         checks++;
         if (!done || edges < 1 || txn_cnt - t0 != (access ? 1 : 0)) begin
            errors++;
            $display("FAIL rand%0d_flow: done=%0d edges=%0d txns=%0d want 1 >=1 %0d",
                     n, done, edges, txn_cnt - t0, access ? 1 : 0);
         end else if (access) begin
            exp_rd = lanes(be, rec_rdata);
            checks++;
            if (rec_addr !== a[19:1] || rec_be !== be || rec_we !== ~rd_n || rec_io !== io ||
                ce1n != exp_w || (!rd_n && rec_wdata !== wd) || (rd_n && rd !== exp_rd)) begin
               errors++;
               $display("FAIL rand%0d_txn: addr=%h/%h be=%b/%b we=%b io=%b ticks=%0d/%0d wd=%h/%h rd=%h/%h",
                        n, rec_addr, a[19:1], rec_be, be, rec_we, rec_io, ce1n, exp_w,
                        rec_wdata, wd, rd, exp_rd);
            end
         end else begin
            checks++;
            if (rd !== 16'hffff) begin
               errors++; $display("FAIL rand%0d_noacc: rdata=%h want ffff", n, rd);
            end
         end
      end
   endtask

`ifdef BUS_TIMEOUT_EN
   task automatic test_timeout;
      bit done; int edges, ce1n, pulses, e0; logic [15:0] rd;
      ack_dly = 0; e0 = err_pulses;
      run_cycle(20'h00300, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1500, 0, done, edges, ce1n, pulses, rd);
      checks++;
      if (!done || rd !== 16'hffff || mem_req !== 1'b0) begin
         errors++; $display("FAIL timeout_done: done=%0d rdata=%h req=%b want 1 ffff 0", done, rd, mem_req);
      end
      checks++;
      if (err_pulses - e0 != 1 || edges < 2 * TIMEOUT) begin
         errors++; $display("FAIL timeout_err: pulses=%0d edges=%0d want 1 >=%0d", err_pulses - e0, edges, 2 * TIMEOUT);
      end
   endtask
`else
   task automatic test_no_error;
      checks++;
      if (err_pulses != 0 || bus_error !== 1'b0) begin
         errors++; $display("FAIL bus_error_tied: pulses=%0d want 0", err_pulses);
      end
   endtask
`endif

   initial begin
      test_reset;
      test_word_read;
      test_byte_write;
      test_io_wait;
      test_no_access;
      test_back_to_back;
      test_reset_access;
      test_random;
`ifdef BUS_TIMEOUT_EN
      test_timeout;
`else
      test_no_error;
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
